// File: rtl/uart_tx.sv
// UART transmitter: small FIFO feeding an 8x-oversampled start/data/stop
// serializer. All line and FSM activity advances only on baud8_tick.
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               baud8_tick,
    input  logic [DATA_BITS-1:0]               tx_data,
    input  logic                               tx_valid,
    output logic                               tx_ready,
    output logic                               tx,
    output logic                               tx_busy,
    output logic                               tx_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} state_t;

    state_t                 state, state_nxt;
    logic [2:0]             os_cnt;
    logic [BW-1:0]          bit_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic                   push, pop, bit_end, last_bit, fifo_nonempty;

    assign tx_ready      = (fifo_count != CW'(FIFO_DEPTH));
    assign push          = tx_valid && tx_ready;
    assign fifo_nonempty = (fifo_count != '0);
    assign bit_end       = baud8_tick && (os_cnt == 3'd7);
    assign last_bit      = (bit_idx == BW'(DATA_BITS - 1));

    // Storage carries no reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= TX_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            os_cnt     <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            tx         <= 1'b1;
            tx_done    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            tx_done    <= bit_end && (state == TX_STOP);

            if (pop) begin
                // Frame start: load from FIFO head, drive start bit.
                shreg  <= mem[rd_ptr];
                tx     <= 1'b0;
                os_cnt <= '0;
            end else if (baud8_tick && state != TX_IDLE) begin
                os_cnt <= bit_end ? 3'd0 : os_cnt + 3'd1;
                if (bit_end) begin
                    case (state)
                        TX_START: begin
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= '0;
                        end
                        TX_DATA: begin
                            if (last_bit) begin
                                tx <= 1'b1;
                            end else begin
                                tx      <= shreg[0];
                                shreg   <= shreg >> 1;
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end
                        default: tx <= 1'b1;
                    endcase
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TX_IDLE:  if (baud8_tick && fifo_nonempty) state_nxt = TX_START;
            TX_START: if (bit_end) state_nxt = TX_DATA;
            TX_DATA:  if (bit_end && last_bit) state_nxt = TX_STOP;
            TX_STOP:  if (bit_end) state_nxt = fifo_nonempty ? TX_START : TX_IDLE;
            default:  state_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_busy = (state != TX_IDLE);
        pop     = baud8_tick && fifo_nonempty &&
                  ((state == TX_IDLE) || (state == TX_STOP && os_cnt == 3'd7));
    end

endmodule
